// File: rtl/full_adder.sv
// Single-bit full adder with 0, 1 or 2 register stages. Also exports the
// generate/propagate terms and a valid flag aligned to the configured latency.
module full_adder #(
  parameter int PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout,
  output logic G,
  output logic P,
  output logic vld_out
);

  // Result packing used throughout: {cout, s, g, p}.
  function automatic logic [3:0] fa_terms(input logic a, input logic b, input logic cin);
    logic g;
    logic p;
    g = a & b;
    p = a ^ b;
    return {g | (p & cin), p ^ cin, g, p};
  endfunction

  logic [3:0] comb_res;
  assign comb_res = fa_terms(A, B, Cin);

  generate
    if (PIPE_STAGES == 32'sd0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      always_comb begin
        {Cout, S, G, P} = comb_res;
        vld_out         = en;
      end
    end else if ((PIPE_STAGES == 32'sd1) || (PIPE_STAGES == 32'sd2)) begin : g_pipe
      logic [3:0] s1_data;
      logic       s1_vld;
      logic [3:0] last_data;
      logic       last_vld;

      // Stage 1 data loads only on sampled cycles; the valid bit shifts every cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_data <= 4'b0000;
          s1_vld  <= 1'b0;
        end else begin
          if (en) begin
            s1_data <= comb_res;
          end else begin
            s1_data <= s1_data;
          end
          s1_vld <= en;
        end
      end

      if (PIPE_STAGES == 32'sd2) begin : g_stage2
        logic [3:0] s2_data;
        logic       s2_vld;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s2_data <= 4'b0000;
            s2_vld  <= 1'b0;
          end else begin
            if (s1_vld) begin
              s2_data <= s1_data;
            end else begin
              s2_data <= s2_data;
            end
            s2_vld <= s1_vld;
          end
        end

        assign last_data = s2_data;
        assign last_vld  = s2_vld;
      end else begin : g_stage1_out
        assign last_data = s1_data;
        assign last_vld  = s1_vld;
      end

      assign {Cout, S, G, P} = last_data;
      assign vld_out         = last_vld;
    end else begin : g_bad_cfg
      $error("full_adder: PIPE_STAGES must be 0, 1 or 2");
      logic unused_in;
      assign unused_in = clk ^ rst_n ^ en ^ (^comb_res);
      assign {Cout, S, G, P} = 4'b0000;
      assign vld_out         = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: three instances (0, 1 and 2 stages) share the
// inputs; each output word is compared as {vld, cout, s, g, p}.
module tb_full_adder;

  logic clk;
  logic rst_n;
  logic en;
  logic a;
  logic b;
  logic cin;

  logic s0, c0, g0, p0, v0;
  logic s1, c1, g1, p1, v1;
  logic s2, c2, g2, p2, v2;

  int checks;
  int errors;

  full_adder #(.PIPE_STAGES(0)) u_fa0 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .Cin(cin),
    .S(s0), .Cout(c0), .G(g0), .P(p0), .vld_out(v0)
  );
  full_adder #(.PIPE_STAGES(1)) u_fa1 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .Cin(cin),
    .S(s1), .Cout(c1), .G(g1), .P(p1), .vld_out(v1)
  );
  full_adder #(.PIPE_STAGES(2)) u_fa2 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .Cin(cin),
    .S(s2), .Cout(c2), .G(g2), .P(p2), .vld_out(v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Vectors as {A,B,Cin}; expectations as {vld=1, cout, s, g, p}, hand-computed.
  logic [2:0] vec [8];
  logic [4:0] exp_tab [8];

  initial begin
    vec[0] = 3'b000; exp_tab[0] = 5'b10000;
    vec[1] = 3'b100; exp_tab[1] = 5'b10101;
    vec[2] = 3'b010; exp_tab[2] = 5'b10101;
    vec[3] = 3'b110; exp_tab[3] = 5'b11010;
    vec[4] = 3'b001; exp_tab[4] = 5'b10100;
    vec[5] = 3'b101; exp_tab[5] = 5'b11001;
    vec[6] = 3'b011; exp_tab[6] = 5'b11001;
    vec[7] = 3'b111; exp_tab[7] = 5'b11110;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    {a, b, cin} = 3'b000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_p1", {v1, c1, s1, g1, p1}, 5'b00000);
    check_val("reset_p2", {v2, c2, s2, g2, p2}, 5'b00000);
    rst_n = 1'b1;

    // Exhaustive back-to-back vectors; stage-2 instance lags by one more cycle
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = vec[i];
      en = 1'b1;
      @(posedge clk);
      #1;
      check_val($sformatf("exh_p1_%0d", i), {v1, c1, s1, g1, p1}, exp_tab[i]);
      if (i == 0) check_val("exh_p2_0", {v2, c2, s2, g2, p2}, 5'b00000);
      else check_val($sformatf("exh_p2_%0d", i), {v2, c2, s2, g2, p2}, exp_tab[i-1]);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    check_val("drain_p2", {v2, c2, s2, g2, p2}, 5'b11110);
    check_val("drain_p1", {v1, c1, s1, g1, p1}, 5'b01110);

    // Enable hold: load 1+0+0, then present 1+1+1 with en low
    {a, b, cin} = 3'b100;
    en = 1'b1;
    @(posedge clk);
    #1;
    check_val("hold_load_p1", {v1, c1, s1, g1, p1}, 5'b10101);
    {a, b, cin} = 3'b111;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("hold_p1_%0d", i), {v1, c1, s1, g1, p1}, 5'b00101);
      check_val($sformatf("hold_p2_%0d", i), {v2, c2, s2, g2, p2},
                (i == 0) ? 5'b10101 : 5'b00101);
    end

    // Two-stage latency with a single sampled input
    {a, b, cin} = 3'b111;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check_val("lat_edge1_p2", {v2, c2, s2, g2, p2}, 5'b00101);
    @(posedge clk);
    #1;
    check_val("lat_edge2_p2", {v2, c2, s2, g2, p2}, 5'b11110);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("lat_after_p2_%0d", i), {v2, c2, s2, g2, p2}, 5'b01110);
    end

    // Asynchronous reset while a result is in flight in the two-stage pipe
    {a, b, cin} = 3'b011;
    en = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_val("arst_p1", {v1, c1, s1, g1, p1}, 5'b00000);
    check_val("arst_p2", {v2, c2, s2, g2, p2}, 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("arst_rel_p1_%0d", i), {v1, c1, s1, g1, p1}, 5'b00000);
      check_val($sformatf("arst_rel_p2_%0d", i), {v2, c2, s2, g2, p2}, 5'b00000);
    end

    // Combinational instance: en toggles, reset level must not matter
    for (int i = 0; i < 8; i++) begin
      logic en_v;
      en_v = (i % 2 == 0) ? 1'b1 : 1'b0;
      {a, b, cin} = vec[i];
      en = en_v;
      rst_n = 1'b0;
      #10;
      check_val($sformatf("comb_rst0_%0d", i), {v0, c0, s0, g0, p0}, {en_v, exp_tab[i][3:0]});
      rst_n = 1'b1;
      #10;
      check_val($sformatf("comb_rst1_%0d", i), {v0, c0, s0, g0, p0}, {en_v, exp_tab[i][3:0]});
      #80;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
